// File: rtl/max3421_pkg.sv
`default_nettype none
// ============================================================================
// Module      : max3421_pkg
// Description : Shared types and helpers for the MAX3421 register-access
//               controller. Holds the controller state encoding, the transfer
//               direction constants and the command-byte builders.
// Revision    : 1.0 - initial release
// ============================================================================
package max3421_pkg;

    // Controller states.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_WAIT  = 3'd1,
        RD_WAIT  = 3'd2,
        RD_GUARD = 3'd3,
        RESP     = 3'd4
    } state_t;

    // Direction bit carried in the MAX3421 command byte.
    localparam logic DIR_WRITE = 1'b1;
    localparam logic DIR_READ  = 1'b0;

    // MAX3421 command byte: register number in [7:3], direction in bit 1,
    // bits 2 and 0 always zero.
    function automatic logic [7:0] mk_cmd(input logic [4:0] reg_addr,
                                          input logic       dir);
        return {reg_addr, 1'b0, dir, 1'b0};
    endfunction

    // The engines shift their message LSB first, while the MAX3421 expects
    // each byte MSB first. Reversing the byte puts bit 7 into message bit 0.
    function automatic logic [7:0] wire_order8(input logic [7:0] data_byte);
        logic [7:0] v_rev;
        for (int i = 0; i < 8; i++) begin
            v_rev[i] = data_byte[7 - i];
        end
        return v_rev;
    endfunction

endpackage
`default_nettype wire

// File: rtl/max3421_spi_mux.sv
`default_nettype none
// ============================================================================
// Module      : max3421_spi_mux
// Description : Combinational SPI pin multiplexer. Routes either the write
//               engine's or the read engine's pins onto the physical bus, or
//               parks the bus in its released state.
// Ports       : i_release            - 1 = drive idle levels (n_ss=1, 0, 0)
//               i_sel_rd             - 1 = read engine owns the bus
//               i_wr_n_ss/mosi/sclk  - write engine pins
//               i_rd_n_ss/mosi/sclk  - read engine pins
//               o_n_ss/o_mosi/o_sclk - physical SPI pins
// Revision    : 1.0 - initial release
// ============================================================================
module max3421_spi_mux (
    input  logic i_release,
    input  logic i_sel_rd,
    input  logic i_wr_n_ss,
    input  logic i_wr_mosi,
    input  logic i_wr_sclk,
    input  logic i_rd_n_ss,
    input  logic i_rd_mosi,
    input  logic i_rd_sclk,
    output logic o_n_ss,
    output logic o_mosi,
    output logic o_sclk
);

    always_comb begin
        o_n_ss = 1'b1;
        o_mosi = 1'b0;
        o_sclk = 1'b0;
        if (!i_release) begin
            if (i_sel_rd) begin
                o_n_ss = i_rd_n_ss;
                o_mosi = i_rd_mosi;
                o_sclk = i_rd_sclk;
            end else begin
                o_n_ss = i_wr_n_ss;
                o_mosi = i_wr_mosi;
                o_sclk = i_wr_sclk;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/max3421_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : max3421_reg_ctrl
// Description : MAX3421 register-access controller. Accepts one register
//               write or single-byte read at a time, builds the wire-ordered
//               command message, sequences the matching SPI engine, muxes the
//               engines onto one bus and returns one response per request.
// Ports       : clk_in, rst_in (async, active-high)
//               req_*            - request channel (valid/ready)
//               rsp_*            - one-cycle response pulse, data, error
//               busy_out         - controller not idle
//               wr_* / rd_*      - write / read engine control and status
//               wr_/rd_ pin ins  - engine SPI pins
//               n_ss/mosi/sclk   - physical SPI pins
// Parameters  : GUARD_CYCLES (>= 1) idle cycles after a read or timeout
//               TIMEOUT_CYCLES      cycles allowed for engine completion
// Revision    : 1.0 - initial release
// ============================================================================
module max3421_reg_ctrl #(
    parameter int GUARD_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic        req_write_in,
    input  logic [4:0]  req_reg_in,
    input  logic [7:0]  req_data_in,
    output logic        rsp_valid_out,
    output logic [7:0]  rsp_data_out,
    output logic        rsp_err_out,
    output logic        busy_out,
    output logic [15:0] wr_msg_out,
    output logic        wr_valid_out,
    input  logic        wr_done_in,
    output logic [8:0]  rd_msg_out,
    output logic        rd_valid_out,
    input  logic        rd_byte_valid_in,
    input  logic [7:0]  rd_byte_in,
    input  logic        wr_n_ss_in,
    input  logic        wr_mosi_in,
    input  logic        wr_sclk_in,
    input  logic        rd_n_ss_in,
    input  logic        rd_mosi_in,
    input  logic        rd_sclk_in,
    output logic        n_ss_out,
    output logic        mosi_out,
    output logic        sclk_out
);
    import max3421_pkg::*;

    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_GD_W = $clog2(GUARD_CYCLES + 1);
    localparam logic [c_TO_W-1:0] c_TO_LIMIT = c_TO_W'(TIMEOUT_CYCLES);
    localparam logic [c_GD_W-1:0] c_GD_LAST  = c_GD_W'(GUARD_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_TO_W-1:0]   r_to_cnt;
    logic [c_GD_W-1:0]   r_guard_cnt;
    logic                r_sel_rd;
    logic                r_err;
    logic [7:0]          r_rd_byte;
    logic [15:0]         r_wr_msg;
    logic [8:0]          r_rd_msg;

    logic                w_idle;
    logic                w_accept;
    logic                w_in_wait;
    logic                w_byte_take;
    logic                w_timeout;
    logic                w_wr_valid;
    logic                w_rd_valid;
    logic                w_rsp_valid;

    assign w_idle      = (r_state == IDLE);
    assign w_accept    = w_idle && req_valid_in;
    assign w_in_wait   = (r_state == WR_WAIT) || (r_state == RD_WAIT);
    assign w_byte_take = (r_state == RD_WAIT) && rd_byte_valid_in;

    // A completion seen on the same edge the limit is reached wins over the
    // timeout, so a late but valid transfer is never reported as an error.
    assign w_timeout = (((r_state == WR_WAIT) && !wr_done_in) ||
                        ((r_state == RD_WAIT) && !rd_byte_valid_in)) &&
                       (r_to_cnt == c_TO_LIMIT);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs. The engine valids are pure
    // state decodes, so they fall on the very edge that samples the
    // engine's done/byte pulse and the engine never sees a restart.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_wr_valid  = 1'b0;
        w_rd_valid  = 1'b0;
        w_rsp_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (req_valid_in) begin
                    w_state_nxt = req_write_in ? WR_WAIT : RD_WAIT;
                end
            end
            WR_WAIT: begin
                w_wr_valid = 1'b1;
                if (wr_done_in) begin
                    w_state_nxt = RESP;
                end else if (w_timeout) begin
                    w_state_nxt = RD_GUARD;
                end
            end
            RD_WAIT: begin
                w_rd_valid = 1'b1;
                if (rd_byte_valid_in || w_timeout) begin
                    w_state_nxt = RD_GUARD;
                end
            end
            RD_GUARD: begin
                if (r_guard_cnt == c_GD_LAST) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_rsp_valid = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: request capture, read byte, error flag and counters.
    // Counters restart from zero on every state change.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wr_msg    <= '0;
            r_rd_msg    <= '0;
            r_sel_rd    <= 1'b0;
            r_err       <= 1'b0;
            r_rd_byte   <= '0;
            r_to_cnt    <= '0;
            r_guard_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_sel_rd  <= !req_write_in;
                r_err     <= 1'b0;
                r_rd_byte <= '0;
                if (req_write_in) begin
                    r_wr_msg <= {wire_order8(req_data_in),
                                 wire_order8(mk_cmd(req_reg_in, DIR_WRITE))};
                end else begin
                    r_rd_msg <= {1'b0, wire_order8(mk_cmd(req_reg_in, DIR_READ))};
                end
            end

            if (w_byte_take) begin
                r_rd_byte <= rd_byte_in;
            end

            if (w_timeout) begin
                r_err <= 1'b1;
            end

            if (w_in_wait && (w_state_nxt == r_state)) begin
                r_to_cnt <= r_to_cnt + c_TO_W'(1);
            end else begin
                r_to_cnt <= '0;
            end

            if ((r_state == RD_GUARD) && (w_state_nxt == RD_GUARD)) begin
                r_guard_cnt <= r_guard_cnt + c_GD_W'(1);
            end else begin
                r_guard_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready_out = w_idle;
    assign busy_out      = !w_idle;
    assign wr_valid_out  = w_wr_valid;
    assign rd_valid_out  = w_rd_valid;
    assign wr_msg_out    = r_wr_msg;
    assign rd_msg_out    = r_rd_msg;
    assign rsp_valid_out = w_rsp_valid;
    assign rsp_data_out  = w_rsp_valid ? r_rd_byte : 8'h00;
    assign rsp_err_out   = w_rsp_valid && r_err;

    max3421_spi_mux u_spi_mux (
        .i_release (w_idle),
        .i_sel_rd  (r_sel_rd),
        .i_wr_n_ss (wr_n_ss_in),
        .i_wr_mosi (wr_mosi_in),
        .i_wr_sclk (wr_sclk_in),
        .i_rd_n_ss (rd_n_ss_in),
        .i_rd_mosi (rd_mosi_in),
        .i_rd_sclk (rd_sclk_in),
        .o_n_ss    (n_ss_out),
        .o_mosi    (mosi_out),
        .o_sclk    (sclk_out)
    );

endmodule
`default_nettype wire

// File: tb/tb_max3421_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_max3421_reg_ctrl
// Description : Directed self-checking bench for max3421_reg_ctrl. Inputs
//               change and outputs are sampled around the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_max3421_reg_ctrl;

    localparam int G = 8;
    localparam int T = 1024;

    logic        clk_in;
    logic        rst_in;
    logic        req_valid_in;
    logic        req_ready_out;
    logic        req_write_in;
    logic [4:0]  req_reg_in;
    logic [7:0]  req_data_in;
    logic        rsp_valid_out;
    logic [7:0]  rsp_data_out;
    logic        rsp_err_out;
    logic        busy_out;
    logic [15:0] wr_msg_out;
    logic        wr_valid_out;
    logic        wr_done_in;
    logic [8:0]  rd_msg_out;
    logic        rd_valid_out;
    logic        rd_byte_valid_in;
    logic [7:0]  rd_byte_in;
    logic        wr_n_ss_in, wr_mosi_in, wr_sclk_in;
    logic        rd_n_ss_in, rd_mosi_in, rd_sclk_in;
    logic        n_ss_out, mosi_out, sclk_out;

    int checks = 0;
    int errors = 0;

    max3421_reg_ctrl #(.GUARD_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .req_valid_in     (req_valid_in),
        .req_ready_out    (req_ready_out),
        .req_write_in     (req_write_in),
        .req_reg_in       (req_reg_in),
        .req_data_in      (req_data_in),
        .rsp_valid_out    (rsp_valid_out),
        .rsp_data_out     (rsp_data_out),
        .rsp_err_out      (rsp_err_out),
        .busy_out         (busy_out),
        .wr_msg_out       (wr_msg_out),
        .wr_valid_out     (wr_valid_out),
        .wr_done_in       (wr_done_in),
        .rd_msg_out       (rd_msg_out),
        .rd_valid_out     (rd_valid_out),
        .rd_byte_valid_in (rd_byte_valid_in),
        .rd_byte_in       (rd_byte_in),
        .wr_n_ss_in       (wr_n_ss_in),
        .wr_mosi_in       (wr_mosi_in),
        .wr_sclk_in       (wr_sclk_in),
        .rd_n_ss_in       (rd_n_ss_in),
        .rd_mosi_in       (rd_mosi_in),
        .rd_sclk_in       (rd_sclk_in),
        .n_ss_out         (n_ss_out),
        .mosi_out         (mosi_out),
        .sclk_out         (sclk_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_in = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        checks++; if (req_ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready_out); end
        checks++; if ({busy_out, rsp_valid_out, rsp_err_out, wr_valid_out, rd_valid_out} !== 5'b0) begin errors++;
            $display("FAIL reset_flags: got %b want 00000", {busy_out, rsp_valid_out, rsp_err_out, wr_valid_out, rd_valid_out}); end
        checks++; if ({wr_msg_out, rd_msg_out, rsp_data_out} !== 33'h0) begin errors++;
            $display("FAIL reset_regs: got %h %h %h want 0", wr_msg_out, rd_msg_out, rsp_data_out); end
        checks++; if ({n_ss_out, mosi_out, sclk_out} !== 3'b100) begin errors++;
            $display("FAIL reset_bus: got %b want 100", {n_ss_out, mosi_out, sclk_out}); end
        rst_in = 1'b0;
    endtask

    task automatic test_idle_bus();
        logic [31:0] rnd;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            rnd = $urandom;
            {wr_n_ss_in, wr_mosi_in, wr_sclk_in, rd_n_ss_in, rd_mosi_in, rd_sclk_in} = rnd[5:0];
            #1;
            checks++; if ({n_ss_out, mosi_out, sclk_out} !== 3'b100) begin errors++;
                $display("FAIL idle_bus: got %b want 100 (pins %b)", {n_ss_out, mosi_out, sclk_out}, rnd[5:0]); end
        end
        {wr_n_ss_in, wr_mosi_in, wr_sclk_in, rd_n_ss_in, rd_mosi_in, rd_sclk_in} = 6'b100100;
    endtask

    task automatic test_write();
        @(negedge clk_in);
        req_valid_in = 1'b1; req_write_in = 1'b1; req_reg_in = 5'd17; req_data_in = 8'h08;
        #1;
        checks++; if (req_ready_out !== 1'b1) begin errors++; $display("FAIL wr_ready_before: got %b want 1", req_ready_out); end
        @(negedge clk_in);
        req_valid_in = 1'b0;
        checks++; if ({req_ready_out, busy_out} !== 2'b01) begin errors++;
            $display("FAIL wr_accept: ready/busy got %b want 01", {req_ready_out, busy_out}); end
        checks++; if (wr_msg_out !== 16'h1051) begin errors++; $display("FAIL wr_msg: got %h want 1051", wr_msg_out); end
        wr_n_ss_in = 1'b0; wr_mosi_in = 1'b1; wr_sclk_in = 1'b1;
        #1;
        checks++; if ({n_ss_out, mosi_out, sclk_out} !== 3'b011) begin errors++;
            $display("FAIL wr_bus_follow: got %b want 011", {n_ss_out, mosi_out, sclk_out}); end
        for (int i = 1; i <= 30; i++) begin
            if (i > 1) @(negedge clk_in);
            checks++; if ({wr_valid_out, rsp_valid_out} !== 2'b10) begin errors++;
                $display("FAIL wr_valid_hold: cycle %0d got %b want 10", i, {wr_valid_out, rsp_valid_out}); end
            if (i == 30) wr_done_in = 1'b1;
        end
        @(negedge clk_in);
        wr_done_in = 1'b0;
        wr_n_ss_in = 1'b1; wr_mosi_in = 1'b0; wr_sclk_in = 1'b0;
        checks++; if (wr_valid_out !== 1'b0) begin errors++; $display("FAIL wr_valid_after_done: got %b want 0", wr_valid_out); end
        checks++; if ({rsp_valid_out, rsp_err_out, rsp_data_out} !== 10'h200) begin errors++;
            $display("FAIL wr_rsp: valid %b err %b data %h want 1 0 00", rsp_valid_out, rsp_err_out, rsp_data_out); end
        @(negedge clk_in);
        checks++; if ({rsp_valid_out, req_ready_out} !== 2'b01) begin errors++;
            $display("FAIL wr_rsp_one_cycle: valid/ready got %b want 01", {rsp_valid_out, req_ready_out}); end
    endtask

    task automatic test_read();
        logic exp_v;
        @(negedge clk_in);
        req_valid_in = 1'b1; req_write_in = 1'b0; req_reg_in = 5'd18; req_data_in = 8'hFF;
        @(negedge clk_in);
        req_valid_in = 1'b0;
        checks++; if ({rd_valid_out, wr_valid_out} !== 2'b10) begin errors++;
            $display("FAIL rd_valid_rise: rd/wr got %b want 10", {rd_valid_out, wr_valid_out}); end
        checks++; if (rd_msg_out !== 9'h009) begin errors++; $display("FAIL rd_msg: got %h want 009", rd_msg_out); end
        rd_n_ss_in = 1'b0;
        for (int c = 0; c < 5; c++) begin
            rd_sclk_in = c[0];
            rd_mosi_in = ~c[0];
            #1;
            checks++; if ({n_ss_out, mosi_out, sclk_out} !== {1'b0, ~c[0], c[0]}) begin errors++;
                $display("FAIL rd_bus_follow: got %b want %b", {n_ss_out, mosi_out, sclk_out}, {1'b0, ~c[0], c[0]}); end
            @(negedge clk_in);
        end
        rd_byte_valid_in = 1'b1; rd_byte_in = 8'hA5;
        for (int k = 1; k <= G + 2; k++) begin
            @(negedge clk_in);
            exp_v = (k == G + 1);
            checks++; if (rsp_valid_out !== exp_v) begin errors++;
                $display("FAIL rd_rsp_timing: k=%0d got %b want %b", k, rsp_valid_out, exp_v); end
            if (k == 1) begin
                checks++; if (rd_valid_out !== 1'b0) begin errors++; $display("FAIL rd_valid_drop: got %b want 0", rd_valid_out); end
            end
            if (k <= G + 1) begin
                checks++; if (n_ss_out !== rd_n_ss_in) begin errors++;
                    $display("FAIL rd_nss_follow: k=%0d got %b want %b", k, n_ss_out, rd_n_ss_in); end
            end else begin
                checks++; if (n_ss_out !== 1'b1) begin errors++; $display("FAIL rd_bus_release: got %b want 1", n_ss_out); end
            end
            if (k == G + 1) begin
                checks++; if ({rsp_err_out, rsp_data_out} !== 9'h0A5) begin errors++;
                    $display("FAIL rd_rsp_data: err %b data %h want 0 a5", rsp_err_out, rsp_data_out); end
            end
            // A stray second byte pulse during the guard must be ignored.
            rd_byte_valid_in = (k == 2);
            rd_byte_in       = (k == 2) ? 8'h3C : 8'h00;
        end
        rd_n_ss_in = 1'b1; rd_mosi_in = 1'b0; rd_sclk_in = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic exp_rsp;
        @(negedge clk_in);
        req_valid_in = 1'b1; req_write_in = 1'b1; req_reg_in = 5'd1; req_data_in = 8'h55;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk_in);
            checks++; if (wr_valid_out && rd_valid_out) begin errors++;
                $display("FAIL b2b_overlap: c=%0d wr %b rd %b", c, wr_valid_out, rd_valid_out); end
            exp_rsp = (c == 6) || (c == 17);
            checks++; if (rsp_valid_out !== exp_rsp) begin errors++;
                $display("FAIL b2b_rsp: c=%0d got %b want %b", c, rsp_valid_out, exp_rsp); end
            if (c >= 1 && c <= 5) begin
                checks++; if ({wr_valid_out, req_ready_out} !== 2'b10) begin errors++;
                    $display("FAIL b2b_held: c=%0d wr/ready got %b want 10", c, {wr_valid_out, req_ready_out}); end
            end
            if (c == 1) begin
                req_write_in = 1'b0; req_reg_in = 5'd2; req_data_in = 8'h00;
            end
            if (c == 5) wr_done_in = 1'b1;
            if (c == 6) begin
                wr_done_in = 1'b0;
                checks++; if ({req_ready_out, rd_valid_out, wr_valid_out} !== 3'b000) begin errors++;
                    $display("FAIL b2b_resp_state: got %b want 000", {req_ready_out, rd_valid_out, wr_valid_out}); end
            end
            if (c == 7) begin
                checks++; if ({req_ready_out, rd_valid_out} !== 2'b10) begin errors++;
                    $display("FAIL b2b_second_accept: ready/rd got %b want 10", {req_ready_out, rd_valid_out}); end
            end
            if (c == 8) begin
                checks++; if ({rd_valid_out, rd_msg_out} !== {1'b1, 9'h008}) begin errors++;
                    $display("FAIL b2b_read_start: rd %b msg %h want 1 008", rd_valid_out, rd_msg_out); end
                req_valid_in = 1'b0;
                rd_byte_valid_in = 1'b1; rd_byte_in = 8'h5A;
            end
            if (c == 9) begin
                rd_byte_valid_in = 1'b0; rd_byte_in = 8'h00;
            end
            if (c == 17) begin
                checks++; if (rsp_data_out !== 8'h5A) begin errors++; $display("FAIL b2b_read_data: got %h want 5a", rsp_data_out); end
            end
        end
    endtask

    task automatic test_timeout();
        int  n;
        bit  seen;
        @(negedge clk_in);
        req_valid_in = 1'b1; req_write_in = 1'b0; req_reg_in = 5'd3;
        @(negedge clk_in);
        req_valid_in = 1'b0;
        n = 1;
        seen = 1'b0;
        while (!seen && n <= T + G + 10) begin
            if (n == T + 1) begin
                checks++; if (rd_valid_out !== 1'b1) begin errors++; $display("FAIL to_rd_valid_last: got %b want 1", rd_valid_out); end
            end
            if (n == T + 2) begin
                checks++; if (rd_valid_out !== 1'b0) begin errors++; $display("FAIL to_rd_valid_drop: got %b want 0", rd_valid_out); end
            end
            if (rsp_valid_out) begin
                seen = 1'b1;
            end else begin
                @(negedge clk_in);
                n++;
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL to_no_response: got none within %0d cycles want one", T + G + 10); end
        checks++; if (n != T + G + 2) begin errors++; $display("FAIL to_latency: got %0d want %0d", n, T + G + 2); end
        checks++; if ({rsp_err_out, rsp_data_out} !== 9'h100) begin errors++;
            $display("FAIL to_rsp: err %b data %h want 1 00", rsp_err_out, rsp_data_out); end
        @(negedge clk_in);
        checks++; if ({n_ss_out, mosi_out, sclk_out, busy_out, rsp_err_out} !== 5'b10000) begin errors++;
            $display("FAIL to_bus_idle: got %b want 10000", {n_ss_out, mosi_out, sclk_out, busy_out, rsp_err_out}); end
    endtask

    task automatic test_async_reset();
        @(negedge clk_in);
        req_valid_in = 1'b1; req_write_in = 1'b1; req_reg_in = 5'd5; req_data_in = 8'h77;
        @(negedge clk_in);
        req_valid_in = 1'b0;
        checks++; if (wr_valid_out !== 1'b1) begin errors++; $display("FAIL ar_started: got %b want 1", wr_valid_out); end
        wr_n_ss_in = 1'b0; wr_sclk_in = 1'b1;
        @(negedge clk_in);
        @(posedge clk_in);
        #3 rst_in = 1'b1;
        #1;
        checks++; if ({n_ss_out, sclk_out, wr_valid_out, busy_out} !== 4'b1000) begin errors++;
            $display("FAIL ar_immediate: nss/sclk/wrv/busy got %b want 1000", {n_ss_out, sclk_out, wr_valid_out, busy_out}); end
        @(negedge clk_in);
        wr_n_ss_in = 1'b1; wr_sclk_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
        wr_done_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            wr_done_in = 1'b0;
            checks++; if ({rsp_valid_out, busy_out} !== 2'b00) begin errors++;
                $display("FAIL ar_no_rsp: cycle %0d rsp/busy got %b want 00", i, {rsp_valid_out, busy_out}); end
        end
        req_valid_in = 1'b1; req_write_in = 1'b1; req_reg_in = 5'd6; req_data_in = 8'h01;
        @(negedge clk_in);
        req_valid_in = 1'b0;
        checks++; if ({wr_valid_out, wr_msg_out} !== {1'b1, 16'h804C}) begin errors++;
            $display("FAIL ar_next_req: wrv %b msg %h want 1 804c", wr_valid_out, wr_msg_out); end
        @(negedge clk_in);
        wr_done_in = 1'b1;
        @(negedge clk_in);
        wr_done_in = 1'b0;
        checks++; if ({rsp_valid_out, rsp_err_out} !== 2'b10) begin errors++;
            $display("FAIL ar_next_rsp: valid/err got %b want 10", {rsp_valid_out, rsp_err_out}); end
    endtask

    initial begin
        rst_in           = 1'b1;
        req_valid_in     = 1'b0;
        req_write_in     = 1'b0;
        req_reg_in       = 5'd0;
        req_data_in      = 8'h00;
        wr_done_in       = 1'b0;
        rd_byte_valid_in = 1'b0;
        rd_byte_in       = 8'h00;
        wr_n_ss_in = 1'b1; wr_mosi_in = 1'b0; wr_sclk_in = 1'b0;
        rd_n_ss_in = 1'b1; rd_mosi_in = 1'b0; rd_sclk_in = 1'b0;

        test_reset();
        test_idle_bus();
        test_write();
        test_read();
        test_back_to_back();
        test_timeout();
        test_async_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
